// File: rtl/dmx_pkg.sv
// Shared constants and state encoding for the DMX512 transmit path.
package dmx_pkg;

    localparam int unsigned DMX_BAUD       = 250000;
    localparam int unsigned DMX_SLOT_BITS  = 11;
    localparam int unsigned DMX_DATA_BITS  = 8;
    localparam int unsigned DMX_STOP_BITS  = DMX_SLOT_BITS - 1 - DMX_DATA_BITS;
    localparam int unsigned DMX_BREAK_BITS = 22;
    localparam int unsigned DMX_MAB_BITS   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_START,
        ST_DATA,
        ST_STOP
    } dmx_state_e;

    // Slot-RAM address width; a single-slot universe still gets one address bit.
    function automatic int unsigned dmx_addr_w(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/dmx_baud_tick.sv
// Clock-enable bit-time divider: bit_tick marks the last cycle of every bit.
module dmx_baud_tick #(
    parameter int unsigned CLOCK_HZ = 50000000,
    parameter int unsigned BAUD     = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned DIV   = CLOCK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || count == CNT_W'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_tick = (count == CNT_W'(DIV - 1));

endmodule

// File: rtl/dmx_frame_sequencer.sv
// DMX512 universe transmitter: BREAK, MAB, start-code slot, then SLOTS data slots
// fetched one slot ahead from the channel-buffer RAM.
module dmx_frame_sequencer
    import dmx_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = 50000000,
    parameter int unsigned BAUD       = DMX_BAUD,
    parameter int unsigned BREAK_BITS = DMX_BREAK_BITS,
    parameter int unsigned MAB_BITS   = DMX_MAB_BITS,
    parameter int unsigned SLOTS      = 512,
    localparam int unsigned ADDR_W    = dmx_addr_w(SLOTS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        start_code,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SLOT_W    = ADDR_W + 1;
    localparam int unsigned LONG_BITS = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
    // The bit counter also times BREAK/MAB, so it widens beyond 4 bits when needed.
    localparam int unsigned BIT_W     = ($clog2(LONG_BITS) > 4) ? $clog2(LONG_BITS) : 4;

    dmx_state_e        state, state_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [SLOT_W-1:0] slot_cnt, slot_cnt_d;
    logic [7:0]        shreg, shreg_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_en_d, rd_pend, rd_pend_d;
    logic              tx_d, busy_d, done_d;
    logic              bit_tick;
    logic              tick_en_c;

    // Clearing on abort keeps the divider at zero the cycle the frame is killed.
    assign tick_en_c = busy & ~abort;

    dmx_baud_tick #(
        .CLOCK_HZ (CLOCK_HZ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clock    (clock),
        .reset    (reset),
        .enable   (tick_en_c),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            shreg    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            slot_cnt <= slot_cnt_d;
            shreg    <= shreg_d;
            rd_en    <= rd_en_d;
            rd_addr  <= rd_addr_d;
            rd_pend  <= rd_pend_d;
            tx       <= tx_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        slot_cnt_d = slot_cnt;
        shreg_d    = shreg;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr;
        rd_pend_d  = rd_en;
        done_d     = 1'b0;

        // RAM answers one cycle after the strobe, during the first stop bit.
        if (rd_pend) begin
            shreg_d = rd_data;
        end

        unique case (state)
            ST_IDLE: begin
                if (start && !abort && !done) begin
                    state_d    = ST_BREAK;
                    shreg_d    = start_code;
                    bit_cnt_d  = '0;
                    slot_cnt_d = '0;
                end
            end
            ST_BREAK: begin
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(BREAK_BITS - 1)) begin
                        state_d   = ST_MAB;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_MAB: begin
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(MAB_BITS - 1)) begin
                        state_d   = ST_START;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(DMX_DATA_BITS - 1)) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                        if (slot_cnt != SLOT_W'(SLOTS)) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = slot_cnt[ADDR_W-1:0];
                        end
                    end else begin
                        shreg_d   = {1'b0, shreg[7:1]};
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(DMX_STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (slot_cnt == SLOT_W'(SLOTS)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_START;
                            slot_cnt_d = slot_cnt + SLOT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
            rd_en_d    = 1'b0;
            rd_pend_d  = 1'b0;
            done_d     = 1'b0;
        end

        unique case (state_d)
            ST_BREAK, ST_START: tx_d = 1'b0;
            ST_DATA:            tx_d = shreg_d[0];
            default:            tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Directed bench for dmx_frame_sequencer with DIV=4 and a four-slot universe.
`timescale 1ns/1ps
module tb_dmx_frame_sequencer;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 2;
    localparam int NS = 340;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    start_code = 8'h00;
    logic [7:0]    rd_data;
    logic          rd_en, tx, busy, done;
    logic [AW-1:0] rd_addr;

    logic [7:0]    ram [SLOTS];
    logic [7:0]    sb [$];
    int            nvec = 0;
    int            nerr = 0;

    logic          tx_s   [1:NS];
    logic          done_s [1:NS];
    logic          busy_s [1:NS];
    logic          rde_s  [1:NS];
    logic [AW-1:0] ra_s   [1:NS];

    dmx_frame_sequencer #(
        .CLOCK_HZ (1000),
        .BAUD     (250),
        .SLOTS    (SLOTS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_code (start_code),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM; junk on idle cycles exposes mistimed latching.
    always @(posedge clock) rd_data <= rd_en ? ram[rd_addr] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] code);
        sb.push_back(code);
        for (int i = 0; i < int'(SLOTS); i++) sb.push_back(ram[i]);
    endtask

    // Sample k is the negedge of the k-th cycle after the accepting edge.
    task automatic run_frame(input logic [7:0] code, input bit hold, input int abort_k,
                             input int rst_k, input int nsamp);
        start_code = code;
        start = 1'b1;
        for (int k = 1; k <= nsamp; k++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            tx_s[k]   = tx;
            done_s[k] = done;
            busy_s[k] = busy;
            rde_s[k]  = rd_en;
            ra_s[k]   = rd_addr;
            abort = (k == abort_k);
            if (rst_k != 0) reset = !(k >= rst_k && k < rst_k + 2);
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
    endtask

    task automatic check_full();
        int run;
        int bad;
        int nrd;
        int k0;
        logic [7:0] d;
        logic [7:0] e;
        chk("accept_busy", 32'(busy_s[1]), 32'd1);
        chk("accept_tx", 32'(tx_s[1]), 32'd0);
        run = 0;
        while (run < 200 && tx_s[run + 1] === 1'b0) run++;
        chk("break_low_cycles", run, 88);
        run = 0;
        while (run < 200 && tx_s[89 + run] === 1'b1) run++;
        chk("mab_high_cycles", run, 12);
        bad = 0;
        for (int b = 0; b < 80; b++)
            for (int j = 1; j < 4; j++)
                if (tx_s[4*b + 1 + j] !== tx_s[4*b + 1]) bad++;
        chk("bit_stable", bad, 0);
        for (int s = 0; s <= int'(SLOTS); s++) begin
            k0 = 101 + 44*s;
            for (int i = 0; i < 8; i++) d[i] = tx_s[k0 + 4*(1 + i) + 1];
            e = 8'hxx;
            if (sb.size() > 0) e = sb.pop_front();
            chk($sformatf("slot%0d_data", s), 32'(d), 32'(e));
            chk($sformatf("slot%0d_start", s), 32'(tx_s[k0 + 1]), 32'd0);
            chk($sformatf("slot%0d_stops", s), {30'd0, tx_s[k0 + 37], tx_s[k0 + 41]}, 32'd3);
        end
        bad = 0;
        for (int k = 1; k <= 320; k++) begin
            if (done_s[k] !== 1'b0) bad++;
            if (busy_s[k] !== 1'b1) bad++;
        end
        chk("busy_no_early_done", bad, 0);
        chk("done_pulse", 32'(done_s[321]), 32'd1);
        chk("done_busy", 32'(busy_s[321]), 32'd0);
        chk("done_tx", 32'(tx_s[321]), 32'd1);
        chk("done_width", 32'(done_s[322]), 32'd0);
        nrd = 0;
        for (int k = 1; k <= 322; k++) begin
            if (rde_s[k] !== 1'b0) begin
                chk("rd_cycle", k, 137 + 44*nrd);
                chk("rd_addr", 32'(ra_s[k]), nrd);
                nrd++;
            end
        end
        chk("rd_count", nrd, 4);
    endtask

    initial begin
        int bad;
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy_done_rden", {29'd0, busy, done, rd_en}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);

        push_frame(8'h00);
        run_frame(8'h00, 1'b0, 0, 0, 330);
        check_full();

        // Start held high through the whole frame and past done.
        ram[0] = 8'hA5; ram[1] = 8'h5A; ram[2] = 8'hFF; ram[3] = 8'h01;
        push_frame(8'hC3);
        run_frame(8'hC3, 1'b1, 0, 0, 323);
        check_full();
        chk("restart_gap_busy", 32'(busy_s[322]), 32'd0);
        chk("restart_busy", 32'(busy_s[323]), 32'd1);
        chk("restart_tx", 32'(tx_s[323]), 32'd0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("restart_abort_busy", 32'(busy), 32'd0);

        // Abort during the third data bit of slot 2.
        run_frame(8'h00, 1'b0, 202, 0, 260);
        chk("abort_pre_busy", 32'(busy_s[202]), 32'd1);
        chk("abort_tx", 32'(tx_s[203]), 32'd1);
        chk("abort_busy", 32'(busy_s[203]), 32'd0);
        bad = 0;
        for (int k = 1; k <= 202; k++) if (rde_s[k] === 1'b1) bad++;
        chk("abort_rd_before", bad, 2);
        bad = 0;
        for (int k = 203; k <= 260; k++)
            if (done_s[k] !== 1'b0 || rde_s[k] !== 1'b0 || busy_s[k] !== 1'b0 || tx_s[k] !== 1'b1) bad++;
        chk("abort_quiet", bad, 0);

        push_frame(8'h00);
        run_frame(8'h00, 1'b0, 0, 0, 330);
        check_full();

        // Reset pulled during MAB.
        run_frame(8'h00, 1'b0, 0, 92, 120);
        chk("midrst_pre_tx", 32'(tx_s[92]), 32'd1);
        chk("midrst_pre_busy", 32'(busy_s[92]), 32'd1);
        for (int k = 93; k <= 94; k++) begin
            chk("midrst_tx", 32'(tx_s[k]), 32'd1);
            chk("midrst_outs", {27'd0, busy_s[k], done_s[k], rde_s[k], ra_s[k]}, 32'd0);
        end
        bad = 0;
        for (int k = 95; k <= 120; k++) if (busy_s[k] !== 1'b0 || tx_s[k] !== 1'b1) bad++;
        chk("midrst_idle", bad, 0);

        push_frame(8'h55);
        run_frame(8'h55, 1'b0, 0, 0, 330);
        check_full();

        // start and abort together in IDLE never launch a frame.
        start = 1'b1;
        abort = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("start_abort_idle", bad, 0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        chk("start_abort_after", {30'd0, busy, tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
